// File: rtl/memoria_datos_lector_pkg.sv
// Shared definitions for the data-memory dump reader: FSM states and counter sizing.
package memoria_datos_lector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } estado_t;

    // One spare bit so the counter can hold NBYTES itself.
    function automatic int unsigned byte_cnt_width(input int unsigned nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

// File: rtl/memoria_datos_lector_if.sv
// Memory read port plus byte stream towards the debug UART transmitter.
interface memoria_datos_lector_if #(
    parameter int unsigned NBITS = 32
) ();
    logic             o_MemRead;
    logic [NBITS-1:0] o_Direccion;
    logic [NBITS-1:0] i_DatoLeido;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             i_tx_ready;

    modport master (
        output o_MemRead, o_Direccion, o_tx_data, o_tx_valid,
        input  i_DatoLeido, i_tx_ready
    );

    modport slave (
        input  o_MemRead, o_Direccion, o_tx_data, o_tx_valid,
        output i_DatoLeido, i_tx_ready
    );
endinterface

// File: rtl/memoria_datos_lector_palabra_a_bytes.sv
// Serialises one NBITS word into bytes, MSB first, over a valid/ready handshake.
module palabra_a_bytes
    import memoria_datos_lector_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_word,
    input  logic             i_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_last
);
    localparam int unsigned NBYTES = NBITS / 8;
    localparam int unsigned CW     = byte_cnt_width(NBYTES);

    logic [NBITS-1:0] shift;
    logic [CW-1:0]    cnt;
    logic             handshake;

    assign handshake = o_valid && i_ready;
    assign o_data    = shift[NBITS-1 -: 8];
    assign o_last    = handshake && (cnt == CW'(NBYTES - 1));

    // After the last shift the register is all zeros, so o_data idles at 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            shift   <= i_word;
            cnt     <= '0;
            o_valid <= 1'b1;
        end else if (handshake) begin
            shift <= shift << 8;
            cnt   <= cnt + 1'b1;
            if (o_last) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memoria_datos_lector.sv
// Debug dump of the data memory: reads cells 0..CELDAS-1 and streams each word out as bytes.
module memoria_datos_lector
    import memoria_datos_lector_pkg::*;
#(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned CELDAS = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    memoria_datos_lector_if.master  bus,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam logic [NBITS-1:0] ULTIMA = NBITS'(CELDAS - 1);

    estado_t          state;
    logic [NBITS-1:0] addr;
    logic             carga;
    logic             last;

    assign bus.o_Direccion = addr;
    assign carga           = (state == WAIT);

    palabra_a_bytes #(
        .NBITS (NBITS)
    ) u_palabra_a_bytes (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (carga),
        .i_word  (bus.i_DatoLeido),
        .i_ready (bus.i_tx_ready),
        .o_data  (bus.o_tx_data),
        .o_valid (bus.o_tx_valid),
        .o_last  (last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            addr          <= '0;
            bus.o_MemRead <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state         <= READ;
                        addr          <= '0;
                        bus.o_MemRead <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end
                READ: begin
                    state         <= WAIT;
                    bus.o_MemRead <= 1'b0;
                end
                WAIT: begin
                    state <= SEND;
                end
                SEND: begin
                    if (last) begin
                        if (addr == ULTIMA) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            addr          <= addr + 1'b1;
                            state         <= READ;
                            bus.o_MemRead <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    addr   <= '0;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    addr          <= '0;
                    bus.o_MemRead <= 1'b0;
                    o_busy        <= 1'b0;
                    o_done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_datos_lector.sv
// Randomised bench for memoria_datos_lector against a queue-based model of the dump sequence.
module tb_memoria_datos_lector;
    localparam int unsigned NBITS  = 32;
    localparam int unsigned CELDAS = 10;
    localparam int unsigned NBYTES = NBITS / 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    memoria_datos_lector_if #(.NBITS(NBITS)) bus ();

    memoria_datos_lector #(
        .NBITS  (NBITS),
        .CELDAS (CELDAS)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .bus     (bus),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    logic [NBITS-1:0] mem [CELDAS];

    // Registered read: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.o_MemRead && (bus.o_Direccion < CELDAS)) begin
            bus.i_DatoLeido <= mem[int'(bus.o_Direccion)];
        end
    end

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0] exp_bytes[$];
    int         exp_addr[$];
    logic [7:0] rx_all[$];
    int         done_cnt = 0;
    int         done_cycle = 0;
    int         read0_cycle = 0;
    int         start_cycle = 0;
    bit         first_pending = 1'b0;
    int         ready_mode = 0;
    int         pat_i = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Expected dump: every cell in address order, each word big-endian.
    task automatic push_dump();
        exp_addr.delete();
        exp_bytes.delete();
        for (int a = 0; a < int'(CELDAS); a++) begin
            exp_addr.push_back(a);
            for (int b = int'(NBYTES) - 1; b >= 0; b--) begin
                exp_bytes.push_back(8'(mem[a] >> (8 * b)));
            end
        end
    endtask

    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.i_tx_ready = 1'b1;
                1: begin
                    bus.i_tx_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                    pat_i++;
                end
                default: bus.i_tx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    bit         prev_stall = 1'b0;
    bit         prev_rd = 1'b0;
    logic [7:0] prev_data = '0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (!busy) begin
                chk("idle_outs", {bus.o_MemRead, bus.o_tx_valid, done, 21'b0, bus.o_tx_data}, 32'h0);
                chk("idle_addr", bus.o_Direccion, 32'h0);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.o_tx_valid, 1);
                chk("stall_data", bus.o_tx_data, prev_data);
            end
            if (prev_rd) begin
                chk("wait_after_read", {bus.o_MemRead, bus.o_tx_valid, busy}, 3'b001);
                chk("wait_addr_hold", bus.o_Direccion, prev_addr);
            end
            if (bus.o_MemRead) begin
                chk("read_no_valid", bus.o_tx_valid, 0);
                chk("read_expected", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) chk("read_addr", bus.o_Direccion, exp_addr.pop_front());
                if (first_pending) begin
                    chk("start_latency", cycle - start_cycle, 1);
                    read0_cycle   = cycle;
                    first_pending = 1'b0;
                end
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                rx_all.push_back(bus.o_tx_data);
                chk("byte_expected", exp_bytes.size() > 0, 1);
                if (exp_bytes.size() > 0) chk("byte_value", bus.o_tx_data, exp_bytes.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
                chk("done_busy", busy, 1);
                chk("done_all_sent", exp_bytes.size() + exp_addr.size(), 0);
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
            prev_rd    = bus.o_MemRead;
            prev_addr  = bus.o_Direccion;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1;
        if (!busy) begin
            push_dump();
            start_cycle   = cycle;
            first_pending = 1'b1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt != d0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic wait_addr(input int a, input bit want_send, input int budget);
        int n;
        n = 0;
        while (!(bus.o_Direccion == a && (want_send ? bus.o_tx_valid : bus.o_MemRead)) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_addr", bus.o_Direccion, a);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, bus.o_MemRead, bus.o_tx_valid, 20'b0, bus.o_tx_data}, 32'h0);
        chk({name, "_addr"}, bus.o_Direccion, 32'h0);
    endtask

    initial begin
        int d;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < int'(CELDAS); i++) mem[i] = 32'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("reset_state");

        // Sequential words, transmitter always ready.
        ready_mode = 0;
        rx_all.delete();
        pulse_start();
        wait_done(200);
        chk("t1_byte_count", rx_all.size(), 40);
        chk("t1_byte3", rx_all[3], 8'h01);
        chk("t1_byte39", rx_all[39], 8'h0A);
        chk("t1_latency", done_cycle - read0_cycle + 1, 61);
        chk("t1_done_once", done_cnt, 1);

        // Known word under a 1,0,0,1 ready pattern.
        for (int i = 0; i < int'(CELDAS); i++) mem[i] = $urandom;
        mem[3] = 32'h12345678;
        ready_mode = 1;
        pat_i = 0;
        rx_all.delete();
        pulse_start();
        wait_done(400);
        chk("t2_byte_count", rx_all.size(), 40);
        chk("t2_b12", rx_all[12], 8'h12);
        chk("t2_b13", rx_all[13], 8'h34);
        chk("t2_b14", rx_all[14], 8'h56);
        chk("t2_b15", rx_all[15], 8'h78);

        // Restart request mid-dump is ignored.
        for (int i = 0; i < int'(CELDAS); i++) mem[i] = $urandom;
        ready_mode = 2;
        d = done_cnt;
        pulse_start();
        wait_addr(4, 1'b0, 500);
        pulse_start();
        wait_done(800);
        chk("t4_done_once", done_cnt - d, 1);

        // Reset while sending word 5, then a clean dump.
        for (int i = 0; i < int'(CELDAS); i++) mem[i] = $urandom;
        pulse_start();
        wait_addr(5, 1'b1, 800);
        rst = 1'b1;
        exp_bytes.delete();
        exp_addr.delete();
        first_pending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("t5_after_reset");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stays_idle", busy, 0);
        rx_all.delete();
        pulse_start();
        wait_done(800);
        chk("t5_byte_count", rx_all.size(), 40);

        // Start and reset together: reset wins.
        @(posedge clk);
        #1;
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        chk_all_zero("t6_reset_wins");
        repeat (4) @(posedge clk);
        #1;
        chk("t6_still_idle", busy, 0);

        // Random contents, random backpressure.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < int'(CELDAS); i++) mem[i] = $urandom;
            rx_all.delete();
            pulse_start();
            wait_done(1000);
            chk("t7_byte_count", rx_all.size(), 40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memoria_datos_lector.md
Name: memoria_datos_lector

Overview:
- Debug-side reader of the data memory: on a start pulse it walks every data-memory cell from address 0 to CELDAS-1.
- For each cell it issues a read, captures the returned word and streams it out as bytes over a valid/ready byte interface.
- The byte interface feeds the UART transmitter of the debug unit.
- Sits beside the data memory; the pipeline is stalled while it owns the memory port, indicated by o_busy.

Parameters:
- NBITS, 32, data word and address width; must be a multiple of 8.
- CELDAS, 10, number of memory words to dump; word-indexed addresses 0..CELDAS-1.
- NBYTES, NBITS/8 (localparam), bytes sent per word.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a dump; ignored while o_busy=1.
- o_MemRead  out  1  read strobe to the data memory.
- o_Direccion  out  NBITS  word address to the data memory.
- i_DatoLeido  in  NBITS  registered memory read data, valid the cycle after o_MemRead.
- o_tx_data  out  8  byte to the transmitter.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts the byte when valid and ready are both high.
- o_busy  out  1  high whenever state is not IDLE.
- o_done  out  1  one-cycle pulse after the last byte of the last word is accepted.

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge): state=IDLE, address counter=0, byte counter=0, shift register=0. All outputs read 0: o_MemRead, o_Direccion, o_tx_data, o_tx_valid, o_busy, o_done. Reset mid-dump abandons the dump immediately with no further reads or bytes.
- The block never writes memory; it has no MemWrite output.
- IDLE: all outputs 0. If i_start=1, go to READ with addr=0.
- READ, 1 cycle: o_MemRead=1, o_Direccion=addr. Go to WAIT.
- WAIT, 1 cycle: o_MemRead=0, o_Direccion holds addr. Capture i_DatoLeido into the shift register at the cycle-ending edge; byte counter=0. Go to SEND.
- SEND:
  - o_tx_valid=1, o_tx_data=shift[NBITS-1:NBITS-8], i.e. MSB byte first (big-endian).
  - On a handshake (valid && ready): shift left by 8 and increment the byte counter.
  - o_tx_data must stay stable, and o_tx_valid must not drop, until the handshake occurs.
  - On the NBYTES-th handshake: if addr==CELDAS-1 go to DONE; otherwise addr++ and go to READ.
- DONE, 1 cycle: o_done=1, o_busy=1. Go to IDLE; addr resets to 0.
- Latency:
  - First READ is the cycle after i_start is sampled.
  - With i_tx_ready held high, each word costs 2+NBYTES cycles (6 at defaults).
  - Full dump takes CELDAS*(2+NBYTES)+1 cycles from the first READ through DONE (61 at defaults).
- Boundaries:
  - i_start while busy: ignored, no restart.
  - i_start and i_reset in the same cycle: reset wins.
  - i_tx_ready low indefinitely: block stalls in SEND and holds its outputs.
  - CELDAS=1: a single word is sent, then DONE.
  - The address counter never exceeds CELDAS-1 and never wraps during a dump.

Decomposition:
- Shared header of localparams:
  - state encoding: IDLE, READ, WAIT, SEND, DONE;
  - NBYTES;
  - byte-counter width clog2(NBYTES)+1.
- One natural sub-module: palabra_a_bytes.
  - NBITS-wide load, shift left by 8 on handshake, valid/ready output.
  - Asserts a last-byte flag on the NBYTES-th byte.
- Top level keeps the FSM and the address counter.

Test Plan:
- Memory model preloaded with words 1..10; pulse i_start; hold i_tx_ready=1. Expect 40 bytes in the order 00 00 00 01, 00 00 00 02, ..., 00 00 00 0A. Expect o_done one cycle, 61 cycles after the first READ. Expect o_busy low afterwards.
- Word 0x12345678 at address 3; i_tx_ready toggling 1,0,0,1. Expect bytes 12 34 56 78 in order. o_tx_data must stay stable while ready=0, and no byte may be duplicated or dropped.
- Check o_MemRead and o_Direccion. Expect exactly one o_MemRead pulse per address, with o_Direccion=0..9 in sequence, each READ followed by WAIT. o_MemRead is never high in SEND, IDLE or DONE.
- Pulse i_start again during a dump, at address 4. Expect no effect: the sequence continues to address 9 and o_done pulses once.
- Assert i_reset for one cycle mid-SEND of word 5. Next cycle expect all outputs 0 and state IDLE. A new i_start then dumps again from address 0.
- i_start and i_reset high in the same cycle: expect the block to remain IDLE with o_busy=0.
